// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: pattern codes, bar colours
// and a width helper for counters sized from their terminal counts.
package vga_pkg;

    typedef logic [11:0] rgb_t;

    localparam logic [1:0] PAT_BLACK = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_EXT   = 2'd3;

    // Bar colours, index 0 (leftmost bar) in the least significant slot.
    localparam logic [7:0][11:0] BAR_TABLE = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter plus active-region and sync decode.
// Instantiated once for the horizontal axis and once for the vertical axis.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int  ACTIVE = 640,
    parameter int  FP     = 16,
    parameter int  SYNC   = 96,
    parameter int  BP     = 48,
    parameter bit  POL    = 1'b0,
    localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int W      = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         i_sclr_n,
    input  logic         i_step,
    output logic [W-1:0] o_cnt,
    output logic         o_last,
    output logic         o_active,
    output logic         o_sync
);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(TOTAL - 1));

    // Advance the position on each step, wrapping after the last position.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!i_sclr_n) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= w_last ? '0 : r_cnt + W'(1);
        end
    end

    // Compare in 32 bits so a region edge equal to TOTAL cannot truncate.
    assign o_active = (int'(r_cnt) < ACTIVE);
    assign o_sync   = (int'(r_cnt) >= ACTIVE + FP && int'(r_cnt) < ACTIVE + FP + SYNC)
                      ? POL : ~POL;
    assign o_cnt    = r_cnt;
    assign o_last   = w_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing and test-pattern generator. Stage 0 holds the raster counters
// (also the request coordinate for an external source); stage 1 registers
// sync, active flag, coordinate and colour one pixel later.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int  H_ACTIVE = 640,
    parameter int  H_FP     = 16,
    parameter int  H_SYNC   = 96,
    parameter int  H_BP     = 48,
    parameter int  V_ACTIVE = 480,
    parameter int  V_FP     = 10,
    parameter int  V_SYNC   = 2,
    parameter int  V_BP     = 33,
    parameter bit  HS_POL   = 1'b0,
    parameter bit  VS_POL   = 1'b0,
    parameter int  PX_DIV   = 4,
    localparam int HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          i_sclr_n,
    input  logic [1:0]    i_mode,
    input  logic [11:0]   i_rgb,
    output logic [HW-1:0] o_req_x,
    output logic [VW-1:0] o_req_y,
    output logic          o_px_en,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [HW-1:0] o_x,
    output logic [VW-1:0] o_y,
    output logic [3:0]    o_vga_red,
    output logic [3:0]    o_vga_green,
    output logic [3:0]    o_vga_blue,
    output logic          o_sof
);

    localparam int DIV_W = cnt_width(PX_DIV);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = cnt_width(BAR_W);

    logic [DIV_W-1:0] r_div;
    logic             r_px_en;
    logic [HW-1:0]    w_h_cnt;
    logic [VW-1:0]    w_v_cnt;
    logic             w_h_last, w_v_last, w_h_act, w_v_act, w_h_sync, w_v_sync;
    logic             w_v_step, w_de, w_chk;
    logic [1:0]       r_mode;
    logic [BW-1:0]    r_bar_sub;
    logic [2:0]       r_bar;
    rgb_t             w_rgb;
    logic             r_de, r_hs, r_vs;
    logic [HW-1:0]    r_x;
    logic [VW-1:0]    r_y;
    rgb_t             r_rgb;

    // Pixel strobe: one clk high every PX_DIV clks, first on the PX_DIV-th edge.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        if (!i_sclr_n) begin
            r_div   <= '0;
            r_px_en <= 1'b0;
        end else if (r_div == DIV_W'(PX_DIV - 1)) begin
            r_div   <= '0;
            r_px_en <= 1'b1;
        end else begin
            r_div   <= r_div + DIV_W'(1);
            r_px_en <= 1'b0;
        end
    end

    assign w_v_step = r_px_en & w_h_last;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clk      (clk),
        .i_sclr_n (i_sclr_n),
        .i_step   (r_px_en),
        .o_cnt    (w_h_cnt),
        .o_last   (w_h_last),
        .o_active (w_h_act),
        .o_sync   (w_h_sync)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clk      (clk),
        .i_sclr_n (i_sclr_n),
        .i_step   (w_v_step),
        .o_cnt    (w_v_cnt),
        .o_last   (w_v_last),
        .o_active (w_v_act),
        .o_sync   (w_v_sync)
    );

    // Latch the pattern only as stage 0 wraps to (0,0) so a frame never mixes modes.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        if (!i_sclr_n) begin
            r_mode <= PAT_BLACK;
        end else if (r_px_en && w_h_last && w_v_last) begin
            r_mode <= i_mode;
        end
    end

    // Bar index tracks h_cnt / (H_ACTIVE/8) by counting pixels within each bar.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        if (!i_sclr_n) begin
            r_bar_sub <= '0;
            r_bar     <= '0;
        end else if (r_px_en) begin
            if (w_h_last) begin
                r_bar_sub <= '0;
                r_bar     <= '0;
            end else if (r_bar_sub == BW'(BAR_W - 1)) begin
                r_bar_sub <= '0;
                r_bar     <= r_bar + 3'd1;
            end else begin
                r_bar_sub <= r_bar_sub + BW'(1);
            end
        end
    end

    assign w_de  = w_h_act & w_v_act;
    // Bit 5 of each coordinate; reads as zero when the counter is narrower.
    assign w_chk = (|((w_h_cnt >> 5) & HW'(1))) ^ (|((w_v_cnt >> 5) & VW'(1)));

    // Pick the colour for the stage-0 pixel; blanking forces black.
    always_comb begin
        // NOTE: default first so every path assigns w_rgb and no latch is inferred.
        w_rgb = 12'h000;
        if (w_de) begin
            case (r_mode)
                PAT_BARS:  w_rgb = BAR_TABLE[r_bar];
                PAT_CHECK: w_rgb = w_chk ? 12'hFFF : 12'h000;
                PAT_EXT:   w_rgb = i_rgb;
                default:   w_rgb = 12'h000;
            endcase
        end
    end

    // Stage 1: capture the stage-0 pixel on each strobe and hold it in between.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        if (!i_sclr_n) begin
            r_de  <= 1'b0;
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_x   <= '0;
            r_y   <= '0;
            r_rgb <= '0;
        end else if (r_px_en) begin
            r_de  <= w_de;
            r_hs  <= w_h_sync;
            r_vs  <= w_v_sync;
            r_x   <= w_h_cnt;
            r_y   <= w_v_cnt;
            r_rgb <= w_rgb;
        end
    end

    assign o_req_x     = w_h_cnt;
    assign o_req_y     = w_v_cnt;
    assign o_px_en     = r_px_en;
    assign o_sof       = r_px_en && (w_h_cnt == '0) && (w_v_cnt == '0);
    assign o_hsync     = r_hs;
    assign o_vsync     = r_vs;
    assign o_de        = r_de;
    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_vga_red   = r_rgb[11:8];
    assign o_vga_green = r_rgb[7:4];
    assign o_vga_blue  = r_rgb[3:0];

endmodule
